// File: rtl/maze_rx_pkg.sv
// Shared types and constants for the maze packet receiver.
// Build with MAZE_RX_PARITY_EN defined for 9-bit frames with even parity.
package maze_rx_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT_END,
    S_CHECK
  } rx_state_e;

  localparam int X_HI  = 7;
  localparam int X_LO  = 6;
  localparam int Y_HI  = 5;
  localparam int Y_LO  = 3;
  localparam int ST_HI = 2;
  localparam int ST_LO = 0;

  typedef enum logic [2:0] {
    ST_UNVISITED    = 3'd0,
    ST_VISITED      = 3'd1,
    ST_WALL         = 3'd2,
    ST_TREASURE_7K  = 3'd3,
    ST_TREASURE_12K = 3'd4,
    ST_TREASURE_17K = 3'd5,
    ST_CURRENT      = 3'd6,
    ST_RESERVED     = 3'd7
  } cell_state_e;

`ifdef MAZE_RX_PARITY_EN
  localparam int FRAME_BITS = 9;
`else
  localparam int FRAME_BITS = 8;
`endif

  // Row in range and cell state not the reserved code.
  function automatic logic pkt_legal(
    input logic [7:0] p,
    input logic [2:0] ymax
  );
    return (p[Y_HI:Y_LO] <= ymax) &&
           (p[ST_HI:ST_LO] != ST_RESERVED);
  endfunction

  // Error counter increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/maze_packet_rx_sync_edge.sv
// Multi-stage input synchroniser with a delay register
// for rising/falling edge detection on the synchronised level.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // Synchroniser chain and one-cycle delayed copy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign lvl_o  = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/maze_packet_rx.sv
// Bit-serial maze-update receiver: sync, framing, range check, error count.
// Optional even-parity 9th bit when MAZE_RX_PARITY_EN is defined.
module maze_packet_rx
  import maze_rx_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int Y_MAX          = 4
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       SER_CLK,
  input  logic       SER_DATA,
  input  logic       SER_EN,
  output logic [7:0] PACKET_OUT,
  output logic       PACKET_VALID,
  output logic       FRAME_ERR,
  output logic [7:0] ERR_COUNT
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(SYNC_STAGES + 2);
  localparam logic [2:0]    YMAX3    = Y_MAX[2:0];
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FILL_END = FW'(SYNC_STAGES + 1);
  localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic sdat_lvl, sdat_rise, sdat_fall;
  logic sen_lvl,  sen_rise,  sen_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk_i  (CLOCK),
    .rst_ni (RESET_N),
    .d_i    (SER_CLK),
    .lvl_o  (sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
    .clk_i  (CLOCK),
    .rst_ni (RESET_N),
    .d_i    (SER_DATA),
    .lvl_o  (sdat_lvl),
    .rise_o (sdat_rise),
    .fall_o (sdat_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
    .clk_i  (CLOCK),
    .rst_ni (RESET_N),
    .d_i    (SER_EN),
    .lvl_o  (sen_lvl),
    .rise_o (sen_rise),
    .fall_o (sen_fall)
  );

  rx_state_e             state_q;
  logic [FRAME_BITS-1:0] sr_q;
  logic [3:0]            cnt_q;
  logic [TW-1:0]         tmo_q;
  logic [7:0]            pkt_q;
  logic                  valid_q;
  logic                  ferr_q;
  logic [7:0]            errc_q;
  logic [FW-1:0]         fill_q;
  logic                  armed_q;

  logic [FRAME_BITS-1:0] sr_d;
  logic [3:0]            cnt_d;
  logic                  last_bit_w;
  logic                  tmo_hit_w;
  logic [7:0]            data_w;
  logic                  frame_ok_w;

  // Next shift-register / bit-count values and frame validity.
  always_comb begin
    sr_d       = {sr_q[FRAME_BITS-2:0], sdat_lvl};
    cnt_d      = cnt_q + 4'd1;
    last_bit_w = (cnt_d == LAST_BIT);
    tmo_hit_w  = (tmo_q == TMO_LAST);
`ifdef MAZE_RX_PARITY_EN
    data_w     = sr_q[8:1];
    frame_ok_w = pkt_legal(data_w, YMAX3) && !(^sr_q);
`else
    data_w     = sr_q;
    frame_ok_w = pkt_legal(data_w, YMAX3);
`endif
  end

  // Arm frame start only after SER_EN is seen low with a filled synchroniser.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      if (fill_q != FILL_END)
        fill_q <= fill_q + FW'(1);
      else if (!sen_lvl)
        armed_q <= 1'b1;
    end
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      pkt_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      errc_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (sen_rise && armed_q) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (sclk_rise) begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            tmo_q <= '0;
            if (last_bit_w) begin
              state_q <= sen_fall ? S_CHECK : S_WAIT_END;
            end else if (sen_fall) begin
              ferr_q  <= 1'b1;
              errc_q  <= sat_inc8(errc_q);
              state_q <= S_IDLE;
            end
          end else if (sen_fall || tmo_hit_w) begin
            ferr_q  <= 1'b1;
            errc_q  <= sat_inc8(errc_q);
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_WAIT_END: begin
          if (sclk_rise || (!sen_fall && tmo_hit_w)) begin
            ferr_q  <= 1'b1;
            errc_q  <= sat_inc8(errc_q);
            state_q <= S_IDLE;
          end else if (sen_fall) begin
            state_q <= S_CHECK;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_CHECK: begin
          if (frame_ok_w) begin
            pkt_q   <= data_w;
            valid_q <= 1'b1;
          end else begin
            ferr_q  <= 1'b1;
            errc_q  <= sat_inc8(errc_q);
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign PACKET_OUT   = pkt_q;
  assign PACKET_VALID = valid_q;
  assign FRAME_ERR    = ferr_q;
  assign ERR_COUNT    = errc_q;

endmodule

// File: tb/tb_maze_packet_rx.sv
// Directed bench for maze_packet_rx.
// Frame length follows MAZE_RX_PARITY_EN.
module tb_maze_packet_rx;

`ifdef MAZE_RX_PARITY_EN
  localparam int FB = 9;
`else
  localparam int FB = 8;
`endif

  logic       CLOCK    = 1'b0;
  logic       RESET_N  = 1'b0;
  logic       SER_CLK  = 1'b0;
  logic       SER_DATA = 1'b0;
  logic       SER_EN   = 1'b0;
  logic [7:0] PACKET_OUT;
  logic       PACKET_VALID;
  logic       FRAME_ERR;
  logic [7:0] ERR_COUNT;

  int nvec = 0;
  int nerr = 0;
  int vcnt = 0;
  int ecnt = 0;
  int both = 0;

  maze_packet_rx dut (
    .CLOCK        (CLOCK),
    .RESET_N      (RESET_N),
    .SER_CLK      (SER_CLK),
    .SER_DATA     (SER_DATA),
    .SER_EN       (SER_EN),
    .PACKET_OUT   (PACKET_OUT),
    .PACKET_VALID (PACKET_VALID),
    .FRAME_ERR    (FRAME_ERR),
    .ERR_COUNT    (ERR_COUNT)
  );

  always #20 CLOCK = ~CLOCK;

  always @(negedge CLOCK) begin
    if (PACKET_VALID) vcnt++;
    if (FRAME_ERR) ecnt++;
    if (PACKET_VALID && FRAME_ERR) both++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic clr();
    vcnt = 0;
    ecnt = 0;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] pk(input logic [7:0] b);
`ifdef MAZE_RX_PARITY_EN
    return {1'b0, b, ^b};
`else
    return {2'b00, b};
`endif
  endfunction

  // Sends n bits MSB first; tog drops SER_EN with the last SER_CLK rise.
  task automatic frame(input logic [9:0] b, input int n, input bit tog);
    SER_EN = 1'b1;
    cyc(6);
    for (int i = n - 1; i >= 0; i--) begin
      SER_DATA = b[i];
      cyc(5);
      SER_CLK = 1'b1;
      if (tog && i == 0) SER_EN = 1'b0;
      cyc(5);
      SER_CLK = 1'b0;
    end
    if (!tog) begin
      cyc(5);
      SER_EN = 1'b0;
    end
    cyc(12);
  endtask

  logic [9:0] t;

  initial begin
    cyc(3);
    #1;
    chk("rst_pkt", PACKET_OUT, 0);
    chk("rst_valid", PACKET_VALID, 0);
    chk("rst_ferr", FRAME_ERR, 0);
    chk("rst_errc", ERR_COUNT, 0);
    RESET_N = 1'b1;
    cyc(8);

    clr();
    frame(pk(8'h99), FB, 1'b0);
    chk("f99_valid", vcnt, 1);
    chk("f99_err", ecnt, 0);
    chk("f99_pkt", PACKET_OUT, 8'h99);
    chk("f99_errc", ERR_COUNT, 0);

    clr();
    frame(10'b10101, 5, 1'b0);
    chk("short_err", ecnt, 1);
    chk("short_valid", vcnt, 0);
    chk("short_errc", ERR_COUNT, 1);
    chk("short_pkt", PACKET_OUT, 8'h99);

    clr();
    frame(pk(8'h29), FB, 1'b0);
    frame(pk(8'h57), FB, 1'b0);
    chk("range_err", ecnt, 2);
    chk("range_valid", vcnt, 0);
    chk("range_errc", ERR_COUNT, 3);
    chk("range_pkt", PACKET_OUT, 8'h99);

    clr();
    frame(pk(8'hE6), FB, 1'b0);
    chk("ymax_valid", vcnt, 1);
    chk("ymax_pkt", PACKET_OUT, 8'hE6);

    clr();
    t = pk(8'h5A);
    t = (t << 1) | 10'd1;
    frame(t, FB + 1, 1'b0);
    chk("long_err", ecnt, 1);
    chk("long_errc", ERR_COUNT, 4);
    chk("long_pkt", PACKET_OUT, 8'hE6);

    clr();
    SER_EN = 1'b1;
    cyc(6);
    for (int i = 0; i < 3; i++) begin
      SER_DATA = 1'b1;
      cyc(5);
      SER_CLK = 1'b1;
      cyc(5);
      SER_CLK = 1'b0;
    end
    cyc(25010);
    chk("tmo_err", ecnt, 1);
    chk("tmo_errc", ERR_COUNT, 5);
    SER_EN = 1'b0;
    cyc(12);
    chk("tmo_idle_err", ecnt, 1);
    clr();
    frame(pk(8'h46), FB, 1'b0);
    chk("f46_valid", vcnt, 1);
    chk("f46_pkt", PACKET_OUT, 8'h46);

    clr();
    frame(pk(8'h0A), FB, 1'b1);
    chk("tog_full_valid", vcnt, 1);
    chk("tog_full_pkt", PACKET_OUT, 8'h0A);
    clr();
    t = pk(8'h0B);
    t = t >> 1;
    frame(t, FB - 1, 1'b1);
    chk("tog_short_err", ecnt, 1);
    chk("tog_short_valid", vcnt, 0);
    chk("tog_short_pkt", PACKET_OUT, 8'h0A);

    clr();
    for (int k = 0; k < 300; k++) frame(10'd1, 1, 1'b0);
    chk("sat_errc", ERR_COUNT, 8'hFF);
    chk("sat_pulses", ecnt, 300);

    clr();
    SER_EN = 1'b1;
    cyc(6);
    for (int i = 0; i < 4; i++) begin
      SER_DATA = 1'b1;
      cyc(5);
      SER_CLK = 1'b1;
      cyc(5);
      SER_CLK = 1'b0;
    end
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_pkt", PACKET_OUT, 0);
    chk("mid_rst_errc", ERR_COUNT, 0);
    chk("mid_rst_valid", PACKET_VALID, 0);
    chk("mid_rst_ferr", FRAME_ERR, 0);
    cyc(4);
    RESET_N = 1'b1;
    cyc(8);
    frame(pk(8'h99), FB, 1'b0);
    chk("en_high_valid", vcnt, 0);
    chk("en_high_err", ecnt, 0);
    chk("en_high_pkt", PACKET_OUT, 0);
    frame(pk(8'h99), FB, 1'b0);
    chk("rearm_valid", vcnt, 1);
    chk("rearm_pkt", PACKET_OUT, 8'h99);

`ifdef MAZE_RX_PARITY_EN
    clr();
    frame(10'b0100110010, 9, 1'b0);
    chk("par0_valid", vcnt, 1);
    chk("par0_err", ecnt, 0);
    clr();
    frame(10'b0100110011, 9, 1'b0);
    chk("par1_err", ecnt, 1);
    chk("par1_valid", vcnt, 0);
`endif

    chk("never_both", both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
